// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared definitions for the voting-session controller: candidate count,
// default parameter values, the session FSM state type and small helpers
// for decoding the candidate button vector.
// -----------------------------------------------------------------------------
package vote_pkg;

    localparam int NUM_CAND        = 4;
    localparam int CAND_W          = 2;
    localparam int DEF_HOLD_CYCLES = 10;
    localparam int DEF_CNT_W       = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        HOLD,
        COMMIT,
        WAIT_REL
    } vote_state_t;

    // True when exactly one button bit is set (clearing the lowest set bit
    // leaves nothing behind).
    function automatic logic is_single(input logic [NUM_CAND-1:0] b);
        return (b != '0) && ((b & (b - NUM_CAND'(1))) == '0);
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [CAND_W-1:0] lowest_idx(input logic [NUM_CAND-1:0] b);
        logic [CAND_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (b[i]) idx = CAND_W'(i);
        end
        return idx;
    endfunction

    // One-hot button pattern belonging to a candidate index.
    function automatic logic [NUM_CAND-1:0] cand_mask(input logic [CAND_W-1:0] idx);
        return NUM_CAND'(1) << idx;
    endfunction

endpackage

// File: rtl/vote_tally_bank.sv
// -----------------------------------------------------------------------------
// vote_tally_bank
// Four saturating vote counters, one per candidate. One counter may be
// incremented per cycle; any counter can be read combinationally.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset, clears every tally
//   inc_en   : increment the counter selected by inc_idx this cycle
//   inc_idx  : candidate whose tally is incremented
//   rd_idx   : candidate whose tally appears on rd_data
//   rd_data  : current tally of candidate rd_idx
// -----------------------------------------------------------------------------
module vote_tally_bank
    import vote_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inc_en,
    input  logic [CAND_W-1:0] inc_idx,
    input  logic [CAND_W-1:0] rd_idx,
    output logic [CNT_W-1:0]  rd_data
);

    logic [CNT_W-1:0] tally [NUM_CAND];

    // NOTE: this small array is built from flops and must read zero after
    // reset, so every entry is cleared; a RAM-style array would be left
    // unreset and initialised by other means.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
        end else if (inc_en && (tally[inc_idx] != '1)) begin
            // Counters stick at all-ones rather than wrapping.
            tally[inc_idx] <= tally[inc_idx] + CNT_W'(1);
        end
    end

    assign rd_data = tally[rd_idx];

endmodule

// File: rtl/vote_session_ctrl.sv
// -----------------------------------------------------------------------------
// vote_session_ctrl
// Voting-booth session controller. An officer opens a ballot with a
// ballot_arm pulse; the voter then holds exactly one candidate button for
// HOLD_CYCLES consecutive cycles to commit a vote. Multiple or changing
// presses are rejected but leave the ballot open for another attempt.
// In result mode the tally of the lowest pressed button is shown on led.
//
// Ports
//   clock       : rising-edge clock
//   reset       : asynchronous active-low reset
//   mode        : 0 = voting, 1 = result display (aborts any open ballot)
//   ballot_arm  : one-cycle officer pulse opening a ballot (IDLE, mode=0 only)
//   button      : candidate buttons, bit i = candidate i
//   led         : registered result display value
//   vote_valid  : one-cycle pulse when a vote commits
//   vote_sel    : committed candidate index, valid with vote_valid
//   vote_reject : one-cycle pulse when a press attempt is rejected
//   armed       : high while a ballot is open
// -----------------------------------------------------------------------------
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                ballot_arm,
    input  logic [NUM_CAND-1:0] button,
    output logic [CNT_W-1:0]    led,
    output logic                vote_valid,
    output logic [CAND_W-1:0]   vote_sel,
    output logic                vote_reject,
    output logic                armed
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);

    vote_state_t         state, state_d;
    logic [HC_W-1:0]     hold_cnt, hold_cnt_d;
    logic [CAND_W-1:0]   cand, cand_d;
    logic                ballot_open, ballot_open_d;

    logic                single_press;
    logic [NUM_CAND-1:0] cand_bit;
    logic                inc_en;
    logic [CAND_W-1:0]   rd_idx;
    logic [CNT_W-1:0]    rd_data;
    logic [CNT_W-1:0]    led_d;

    assign single_press = is_single(button);
    assign cand_bit     = cand_mask(cand);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            cand        <= '0;
            ballot_open <= 1'b0;
        end else begin
            state       <= state_d;
            hold_cnt    <= hold_cnt_d;
            cand        <= cand_d;
            ballot_open <= ballot_open_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default at the top of the block, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state;
        hold_cnt_d    = hold_cnt;
        cand_d        = cand;
        ballot_open_d = ballot_open;

        if (mode) begin
            // Result mode aborts whatever is in progress without committing.
            state_d       = IDLE;
            hold_cnt_d    = '0;
            ballot_open_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ballot_arm) begin
                        state_d       = ARMED;
                        ballot_open_d = 1'b1;
                        hold_cnt_d    = '0;
                    end
                end

                ARMED: begin
                    if (button != '0) begin
                        if (single_press) begin
                            cand_d     = lowest_idx(button);
                            hold_cnt_d = HC_W'(1);
                            // The first sampled cycle already counts as one.
                            state_d    = (HOLD_CYCLES <= 1) ? COMMIT : HOLD;
                        end else begin
                            state_d = WAIT_REL;
                        end
                    end
                end

                HOLD: begin
                    if (button == cand_bit) begin
                        hold_cnt_d = hold_cnt + HC_W'(1);
                        if (hold_cnt == HC_W'(HOLD_CYCLES - 1)) begin
                            state_d = COMMIT;
                        end
                    end else begin
                        state_d    = WAIT_REL;
                        hold_cnt_d = '0;
                    end
                end

                COMMIT: begin
                    state_d       = WAIT_REL;
                    hold_cnt_d    = '0;
                    ballot_open_d = 1'b0;
                end

                WAIT_REL: begin
                    if (button == '0) begin
                        state_d = ballot_open ? ARMED : IDLE;
                    end
                end

                default: begin
                    state_d       = IDLE;
                    hold_cnt_d    = '0;
                    ballot_open_d = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        vote_valid  = 1'b0;
        vote_sel    = '0;
        vote_reject = 1'b0;

        // Result mode suppresses both commit and reject in the same cycle.
        if (!mode) begin
            case (state)
                ARMED:   vote_reject = (button != '0) && !single_press;
                HOLD:    vote_reject = (button != cand_bit);
                COMMIT: begin
                    vote_valid = 1'b1;
                    vote_sel   = cand;
                end
                default: ;
            endcase
        end

        armed = ballot_open &&
                ((state == ARMED) || (state == HOLD) || (state == WAIT_REL));
    end

    assign inc_en = vote_valid;

    // -------------------------------------------------------------------------
    // Tally storage and result display
    // -------------------------------------------------------------------------
    assign rd_idx = lowest_idx(button);

    vote_tally_bank #(
        .CNT_W (CNT_W)
    ) u_tally_bank (
        .clock   (clock),
        .reset   (reset),
        .inc_en  (inc_en),
        .inc_idx (cand),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign led_d = (mode && (button != '0)) ? rd_data : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= led_d;
        end
    end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 10: consecutive cycles a single button must be held before a vote commits.
REQ-002 SHALL have parameter CNT_W, default 8: width of each candidate tally.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port mode, input, 1: 0 = voting, 1 = result display.
REQ-006 SHALL have port ballot_arm, input, 1: single-cycle officer pulse that enables one vote.
REQ-007 SHALL have port button, input, 4: candidate buttons; bit i is candidate i, synchronous to clock.
REQ-008 SHALL have port led, output, CNT_W: result display value.
REQ-009 SHALL have port vote_valid, output, 1: one-cycle pulse when a vote commits.
REQ-010 SHALL have port vote_sel, output, 2: index of the candidate committed; valid while vote_valid is high.
REQ-011 SHALL have port vote_reject, output, 1: one-cycle pulse when a press attempt is rejected.
REQ-012 SHALL have port armed, output, 1: high while a ballot is open.

Function
REQ-013 SHALL implement FSM states IDLE, ARMED, HOLD, COMMIT and WAIT_REL.
REQ-014 IDLE: ballot_arm=1 with mode=0 -> ARMED; buttons SHALL be ignored.
REQ-015 ARMED with exactly one button bit set -> HOLD, hold_cnt=1, latched candidate = that index.
REQ-016 ARMED with two or more bits set -> WAIT_REL, vote_reject pulsed; the ballot stays open after release.
REQ-017 HOLD with the same single bit still set: hold_cnt++; when hold_cnt==HOLD_CYCLES -> COMMIT.
REQ-018 HOLD with the bit dropped or any other bit set -> WAIT_REL with vote_reject pulse; the ballot stays open.
REQ-019 COMMIT, one cycle: tally[cand]++ saturating at 2^CNT_W-1; vote_valid=1; vote_sel=cand; ballot closes; -> WAIT_REL.
REQ-020 WAIT_REL: when button==0, -> ARMED if the ballot is still open, else -> IDLE.
REQ-021 Latency: with the first sampled press in cycle k, vote_valid SHALL be high in cycle k+HOLD_CYCLES.
REQ-022 mode=1 in any state SHALL force IDLE on the next edge, close the ballot, commit nothing and issue no reject.
REQ-023 ballot_arm outside IDLE, or with mode=1, SHALL be ignored.
REQ-024 led SHALL equal tally of the lowest-index pressed button when mode=1, and 0 when mode=1 with no button or when mode=0 (registered, 1-cycle latency).
REQ-025 armed SHALL be high in ARMED, HOLD and WAIT_REL while the ballot is open.
REQ-026 Only one vote SHALL commit per ballot_arm.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, all tallies 0, hold_cnt 0, ballot closed, and led, vote_valid, vote_sel, vote_reject and armed all 0.
REQ-028 reset deassertion mid-press SHALL require a new ballot_arm; a held button SHALL NOT commit.

Structure
REQ-029 A shared package vote_pkg SHALL hold the FSM state enum, NUM_CAND=4 and the default HOLD_CYCLES/CNT_W.
REQ-030 The tallies SHALL live in one sub-module, vote_tally_bank: 4 saturating CNT_W counters with increment index/enable and a read index.

Verification
REQ-031 Arm, hold button=4'b0001 for 10 cycles -> vote_valid in cycle k+10 with vote_sel=0; mode=1 with button0 -> led=1.
REQ-032 Arm, press 4'b0110 -> vote_reject pulse; release, then hold 4'b0100 for 10 cycles -> tally2=1, tally1=0.
REQ-033 Press 4'b0001 without arming for 50 cycles -> no vote_valid, all tallies 0.
REQ-034 Arm, hold button1 for 5 cycles, then assert mode=1 -> IDLE, armed=0, tally1=0, no reject.
REQ-035 With CNT_W=2, commit 5 votes to candidate 3 -> led=3 in result mode (saturated).
REQ-036 Assert reset low mid-HOLD -> all outputs 0 immediately, without a clock edge; tallies 0 after release.
